// File: rtl/vend_pkg.sv
// Shared types and constants for the coin collector front end:
// the FSM state encoding, coin codes and values, and the credit width.
package vend_pkg;

    localparam int CREDIT_W = 4;
    localparam logic [CREDIT_W:0] CREDIT_LIMIT = 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_REQ     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_REFUND  = 3'd4
    } state_e;

    localparam logic [1:0] COIN_1   = 2'b00;
    localparam logic [1:0] COIN_2   = 2'b01;
    localparam logic [1:0] COIN_5   = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam logic [2:0] VAL_1 = 3'd1;
    localparam logic [2:0] VAL_2 = 3'd2;
    localparam logic [2:0] VAL_5 = 3'd5;

    // Face value of a coin code; the invalid code is worth nothing.
    function automatic logic [2:0] coin_value(input logic [1:0] coin_code);
        logic [2:0] v;
        case (coin_code)
            COIN_1:  v = VAL_1;
            COIN_2:  v = VAL_2;
            COIN_5:  v = VAL_5;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

    // True when adding the coin keeps the credit inside its 4-bit range.
    function automatic logic coin_fits(input logic [CREDIT_W-1:0] cur_credit,
                                       input logic [2:0]          value);
        logic [CREDIT_W:0] sum;
        sum = {1'b0, cur_credit} + {2'b00, value};
        return (sum <= CREDIT_LIMIT);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Counts idle cycles while enabled; done is raised during the
// TIMEOUT_CYCLES-th enabled cycle since the last clear.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Idle counter: clear wins, saturates at the last count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign done = enable && (r_count == LAST);

endmodule

// File: rtl/coin_collector.sv
// Vending front end: accumulates coins, forwards a purchase request to the
// downstream vend stage, and returns change or refunds on cancel/timeout.
module coin_collector
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                sel_valid,
    input  logic [1:0]          sel_item,
    input  logic                cancel,
    input  logic                dispense,
    input  logic [CREDIT_W-1:0] change,
    output logic [CREDIT_W-1:0] money_inserted,
    output logic [1:0]          item_select,
    output logic                coin_reject,
    output logic                vend_ok,
    output logic                short_funds,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amt,
    output logic [CREDIT_W-1:0] credit
);

    state_e              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_money;
    logic [1:0]          r_item;
    logic                r_coin_reject;
    logic                r_vend_ok;
    logic                r_short_funds;
    logic                r_refund_valid;
    logic [CREDIT_W-1:0] r_refund_amt;

    state_e              w_state;
    logic [CREDIT_W-1:0] w_credit;
    logic [CREDIT_W-1:0] w_money;
    logic [1:0]          w_item;
    logic                w_coin_reject;
    logic                w_vend_ok;
    logic                w_short_funds;
    logic                w_refund_valid;
    logic [CREDIT_W-1:0] w_refund_amt;
    logic                w_timer_clear;
    logic                w_timer_en;
    logic                w_timer_done;
    logic [2:0]          w_coin_val;
    logic                w_coin_ok;
    logic [CREDIT_W-1:0] w_credit_plus;

    assign w_coin_val    = coin_value(coin_type);
    assign w_coin_ok     = coin_valid && (coin_type != COIN_BAD) &&
                           coin_fits(r_credit, w_coin_val);
    assign w_credit_plus = r_credit + {1'b0, w_coin_val};
    assign w_timer_en    = (r_state == ST_COLLECT);

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .done    (w_timer_done)
    );

    // Next-state and next-output logic; any coin not explicitly accepted is rejected.
    always_comb begin
        w_state        = r_state;
        w_credit       = r_credit;
        w_money        = '0;
        w_item         = r_item;
        w_coin_reject  = coin_valid;
        w_vend_ok      = 1'b0;
        w_short_funds  = 1'b0;
        w_refund_valid = 1'b0;
        w_refund_amt   = r_refund_amt;
        w_timer_clear  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_coin_ok) begin
                    w_credit      = w_credit_plus;
                    w_coin_reject = 1'b0;
                    w_timer_clear = 1'b1;
                    w_state       = ST_COLLECT;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    w_state = ST_REFUND;
                end else if (sel_valid) begin
                    w_item  = sel_item;
                    w_money = r_credit;
                    w_state = ST_REQ;
                end else if (w_coin_ok) begin
                    w_credit      = w_credit_plus;
                    w_coin_reject = 1'b0;
                    w_timer_clear = 1'b1;
                end else if (w_timer_done) begin
                    w_state = ST_REFUND;
                end else begin
                    w_state = ST_COLLECT;
                end
            end
            ST_REQ: begin
                w_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (dispense) begin
                    w_vend_ok = 1'b1;
                    w_credit  = '0;
                    w_state   = ST_IDLE;
                    if (change != '0) begin
                        w_refund_valid = 1'b1;
                        w_refund_amt   = change;
                    end else begin
                        w_refund_valid = 1'b0;
                    end
                end else begin
                    w_short_funds = 1'b1;
                    w_timer_clear = 1'b1;
                    w_state       = ST_COLLECT;
                end
            end
            ST_REFUND: begin
                w_refund_valid = 1'b1;
                w_refund_amt   = r_credit;
                w_credit       = '0;
                w_state        = ST_IDLE;
            end
            default: begin
                w_credit = '0;
                w_state  = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_money        <= '0;
            r_item         <= 2'b00;
            r_coin_reject  <= 1'b0;
            r_vend_ok      <= 1'b0;
            r_short_funds  <= 1'b0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
        end else begin
            r_state        <= w_state;
            r_credit       <= w_credit;
            r_money        <= w_money;
            r_item         <= w_item;
            r_coin_reject  <= w_coin_reject;
            r_vend_ok      <= w_vend_ok;
            r_short_funds  <= w_short_funds;
            r_refund_valid <= w_refund_valid;
            r_refund_amt   <= w_refund_amt;
        end
    end

    assign money_inserted = r_money;
    assign item_select    = r_item;
    assign coin_reject    = r_coin_reject;
    assign vend_ok        = r_vend_ok;
    assign short_funds    = r_short_funds;
    assign refund_valid   = r_refund_valid;
    assign refund_amt     = r_refund_amt;
    assign credit         = r_credit;

endmodule

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector: directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_coin_collector;

    localparam int TO = 12;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_REQ     = 2;
    localparam int M_WAIT    = 3;
    localparam int M_REFUND  = 4;

    logic       clk;
    logic       reset_n;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       dispense;
    logic [3:0] change;
    logic [3:0] money_inserted;
    logic [1:0] item_select;
    logic       coin_reject;
    logic       vend_ok;
    logic       short_funds;
    logic       refund_valid;
    logic [3:0] refund_amt;
    logic [3:0] credit;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state and expected outputs
    int m_mode, m_credit, m_item, m_idle, m_req_money;
    int e_credit, e_money, e_item, e_rej, e_vend, e_short, e_rv, e_ramt;

    coin_collector #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .coin_valid     (coin_valid),
        .coin_type      (coin_type),
        .sel_valid      (sel_valid),
        .sel_item       (sel_item),
        .cancel         (cancel),
        .dispense       (dispense),
        .change         (change),
        .money_inserted (money_inserted),
        .item_select    (item_select),
        .coin_reject    (coin_reject),
        .vend_ok        (vend_ok),
        .short_funds    (short_funds),
        .refund_valid   (refund_valid),
        .refund_amt     (refund_amt),
        .credit         (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_item = 0; m_idle = 0; m_req_money = 0;
        e_credit = 0; e_money = 0; e_item = 0; e_rej = 0;
        e_vend = 0; e_short = 0; e_rv = 0; e_ramt = 0;
    endtask

    // One clock of the purchase protocol, described by credit and transaction phase.
    task automatic model_step(input logic cv, input logic [1:0] ct, input logic sv,
                              input logic [1:0] si, input logic cn, input logic dp,
                              input logic [3:0] ch);
        int val;
        val = (ct == 2'd0) ? 1 : (ct == 2'd1) ? 2 : (ct == 2'd2) ? 5 : 0;
        e_rej = 0; e_vend = 0; e_short = 0; e_rv = 0; e_money = 0;
        case (m_mode)
            M_IDLE: begin
                if (cv && val != 0) begin
                    m_credit = val; m_idle = 0; m_mode = M_COLLECT;
                end else begin
                    e_rej = int'(cv);
                end
            end
            M_COLLECT: begin
                if (cn) begin
                    e_rej = int'(cv); m_mode = M_REFUND;
                end else if (sv) begin
                    e_rej = int'(cv); m_item = int'(si);
                    e_money = m_credit; m_req_money = m_credit; m_mode = M_REQ;
                end else if (cv && val != 0 && m_credit + val <= 15) begin
                    m_credit += val; m_idle = 0;
                end else begin
                    e_rej = int'(cv); m_idle++;
                    if (m_idle >= TO) m_mode = M_REFUND;
                end
            end
            M_REQ: begin
                e_rej = int'(cv); m_mode = M_WAIT;
            end
            M_WAIT: begin
                e_rej = int'(cv);
                if (dp) begin
                    e_vend = 1; m_credit = 0; m_mode = M_IDLE;
                    if (ch != 4'd0) begin e_rv = 1; e_ramt = int'(ch); end
                end else begin
                    e_short = 1; m_idle = 0; m_mode = M_COLLECT;
                end
            end
            M_REFUND: begin
                e_rej = int'(cv); e_rv = 1; e_ramt = m_credit;
                m_credit = 0; m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
        e_credit = m_credit;
        e_item = m_item;
    endtask

    task automatic check_outputs();
        check_eq("credit", 32'(credit), e_credit);
        check_eq("money_inserted", 32'(money_inserted), e_money);
        check_eq("item_select", 32'(item_select), e_item);
        check_eq("coin_reject", 32'(coin_reject), e_rej);
        check_eq("vend_ok", 32'(vend_ok), e_vend);
        check_eq("short_funds", 32'(short_funds), e_short);
        check_eq("refund_valid", 32'(refund_valid), e_rv);
        if (e_rv != 0) check_eq("refund_amt", 32'(refund_amt), e_ramt);
    endtask

    // Drive one cycle of inputs, advance the model, check after the edge.
    task automatic run_cycle(input logic cv, input logic [1:0] ct, input logic sv,
                             input logic [1:0] si, input logic cn, input logic dp,
                             input logic [3:0] ch);
        coin_valid = cv; coin_type = ct; sel_valid = sv; sel_item = si;
        cancel = cn; dispense = dp; change = ch;
        model_step(cv, ct, sv, si, cn, dp, ch);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic coin(input logic [1:0] ct);
        run_cycle(1'b1, ct, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic quiet();
        run_cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_credit"}, 32'(credit), 0);
        check_eq({tag, "_money"}, 32'(money_inserted), 0);
        check_eq({tag, "_item"}, 32'(item_select), 0);
        check_eq({tag, "_ramt"}, 32'(refund_amt), 0);
        check_eq({tag, "_pulses"}, 32'({coin_reject, vend_ok, short_funds, refund_valid}), 0);
    endtask

    initial begin
        logic       cv, sv, cn, dp, seen;
        logic [1:0] ct, si;
        logic [3:0] ch;
        int         price;

        reset_n = 1'b0; coin_valid = 1'b0; coin_type = 2'd0; sel_valid = 1'b0;
        sel_item = 2'd0; cancel = 1'b0; dispense = 1'b0; change = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // coins 5,5 then item 0: request carries 10, vend with change 5
        coin(2'd2); coin(2'd2);
        run_cycle(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 4'd0);
        check_eq("vend_req_money", 32'(money_inserted), 10);
        quiet();
        run_cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 4'd5);
        check_eq("vend_refund_amt", 32'(refund_amt), 5);

        // coins 5,1 then item 3 refused: short funds, credit kept at 6
        coin(2'd2); coin(2'd0);
        run_cycle(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 4'd0);
        quiet();
        run_cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd9);
        check_eq("short_credit", 32'(credit), 6);
        run_cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 4'd0);
        quiet();

        // fill to 15, then overflow coin and invalid coin are rejected
        coin(2'd2); coin(2'd2); coin(2'd2);
        coin(2'd0);
        check_eq("overflow_credit", 32'(credit), 15);
        coin(2'd3);
        check_eq("bad_coin_reject", 32'(coin_reject), 1);
        run_cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 4'd0);
        quiet();

        // coin 2, then cancel together with a coin: coin rejected, refund 2
        coin(2'd1);
        run_cycle(1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 4'd0);
        quiet();
        check_eq("cancel_refund_amt", 32'(refund_amt), 2);

        // coin 1 then silence until the automatic refund
        coin(2'd0);
        seen = 1'b0;
        for (int k = 0; k < TO + 3; k++) begin
            quiet();
            if (refund_valid && refund_amt == 4'd1) seen = 1'b1;
        end
        check_eq("timeout_refund_seen", 32'(seen), 1);

        // reset while waiting for the vend result: no refund afterwards
        coin(2'd2);
        run_cycle(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 4'd0);
        quiet();
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_in_wait");
        model_reset();
        dispense = 1'b1; change = 4'd5;
        @(negedge clk);
        check_eq("reset_in_wait_no_refund", 32'(refund_valid), 0);
        reset_n = 1'b1;
        quiet();

        // random traffic with a priced downstream stage
        for (int i = 0; i < 3000; i++) begin
            cv = ($urandom_range(0, 9) < 3);
            ct = 2'($urandom_range(0, 3));
            sv = ($urandom_range(0, 14) == 0);
            si = 2'($urandom_range(0, 3));
            cn = ($urandom_range(0, 29) == 0);
            dp = 1'($urandom_range(0, 1));
            ch = 4'($urandom_range(0, 15));
            if ((i % 200) < 20) begin
                cv = 1'b0; sv = 1'b0; cn = 1'b0;
            end
            if (m_mode == M_WAIT) begin
                price = (m_item == 0) ? 10 : (m_item == 1) ? 4 : (m_item == 2) ? 7 : 16;
                dp = (m_req_money >= price);
                if (dp) ch = 4'(m_req_money - price);
            end
            run_cycle(cv, ct, sv, si, cn, dp, ch);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coin_collector.md
COIN_COLLECTOR -- requirements
Module: coin_collector

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, SHALL set the idle cycles in COLLECT before an automatic refund.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 coin_valid  input  1  SHALL be a one-cycle coin-insert strobe.
REQ-005 coin_type  input  2  SHALL encode coin value: 00=1, 01=2, 10=5, 11=invalid.
REQ-006 sel_valid  input  1  SHALL be a one-cycle item-select strobe.
REQ-007 sel_item  input  2  SHALL be the item code, sampled with sel_valid.
REQ-008 cancel  input  1  SHALL be a one-cycle user-cancel strobe.
REQ-009 dispense  input  1  SHALL be the registered vend result from the downstream vending stage.
REQ-010 change  input  4  SHALL be the registered change or refund from the downstream vending stage.
REQ-011 money_inserted  output  4  SHALL be the credit presented downstream.
REQ-012 item_select  output  2  SHALL be the item presented downstream.
REQ-013 coin_reject  output  1  SHALL be a one-cycle pulse when a coin is not accepted.
REQ-014 vend_ok  output  1  SHALL be a one-cycle pulse on a successful vend.
REQ-015 short_funds  output  1  SHALL be a one-cycle pulse when the credit was insufficient.
REQ-016 refund_valid  output  1  SHALL be a one-cycle pulse qualifying refund_amt.
REQ-017 refund_amt  output  4  SHALL be the coins returned to the user.
REQ-018 credit  output  4  SHALL be the current accumulated credit, for display.

Function
REQ-019 The FSM SHALL have the states IDLE, COLLECT, REQ, WAIT and REFUND.
REQ-020 IDLE SHALL have credit 0; an accepted coin SHALL add its value and move the FSM to COLLECT.
REQ-021 A coin SHALL be accepted only in IDLE or COLLECT, only with coin_type!=11, and only if credit+value<=15.
- Otherwise coin_reject SHALL pulse in the next cycle and credit SHALL be unchanged.
- No wrap-around is permitted.
REQ-022 The COLLECT priority SHALL be cancel > sel_valid > coin_valid.
- A coin that coincides with sel_valid or cancel SHALL be rejected.
REQ-023 cancel in COLLECT SHALL move the FSM to REFUND.
REQ-024 sel_valid in COLLECT SHALL latch sel_item and move the FSM to REQ.
REQ-025 sel_valid and cancel in IDLE SHALL be ignored.
REQ-026 REQ SHALL last exactly one cycle and drive money_inserted=credit and item_select=latched item.
- In every other state, money_inserted SHALL be 0 and item_select SHALL hold its last value.
REQ-027 WAIT SHALL last exactly one cycle and sample dispense and change, which are the downstream response to the REQ cycle.
REQ-028 If dispense=1 in WAIT:
- vend_ok SHALL pulse and credit SHALL clear.
- If change!=0, refund_valid SHALL pulse with refund_amt=change; the FSM SHALL then go to IDLE.
REQ-029 If dispense=0 in WAIT: short_funds SHALL pulse, credit SHALL be retained and the FSM SHALL return to COLLECT.
REQ-030 REFUND SHALL last one cycle, pulse refund_valid with refund_amt=credit, clear credit and go to IDLE.
REQ-031 The idle timer SHALL restart on entry to COLLECT and on every accepted coin.
- On reaching TIMEOUT_CYCLES, the FSM SHALL go to REFUND.
REQ-032 cancel, coin_valid and sel_valid SHALL be ignored in REQ, WAIT and REFUND; coins there SHALL be rejected per REQ-021.
REQ-033 All outputs SHALL be registered; pulses SHALL be exactly one cycle wide.

Reset
REQ-034 On reset_n low, the FSM SHALL enter IDLE immediately.
- credit, money_inserted, item_select, refund_amt SHALL be 0.
- All pulse outputs SHALL be 0.
- The idle timer SHALL be 0.
REQ-035 Reset during REQ or WAIT SHALL abandon the transaction with no refund pulse.

Structure
REQ-036 Package vend_pkg SHALL hold the FSM state typedef, the coin encodings and values, and CREDIT_W=4.
REQ-037 The idle timer SHALL be a sub-module, idle_timer, with inputs clear and enable and a done output.

Verification
REQ-038 Coins 5,5 then sel 00 -> REQ presents money_inserted=10; WAIT sees dispense=1, change=5 -> vend_ok and refund_valid with refund_amt=5, then IDLE.
REQ-039 Coins 5,1 then sel 11 -> short_funds pulses, credit stays 6, FSM returns to COLLECT.
REQ-040 Coins 5,5,5 then coin 1 -> coin_reject pulses, credit stays 15; coin_type=11 -> coin_reject pulses.
REQ-041 Coin 2, then cancel and coin_valid in the same cycle -> coin rejected, refund_amt=2, IDLE.
REQ-042 Coin 1, then idle for TIMEOUT_CYCLES -> refund_valid with refund_amt=1.
REQ-043 reset_n low during WAIT -> all outputs 0 immediately, IDLE, no refund pulse.
